// File: rtl/algo_chk_pkg.sv
// Shared types and helpers for the N-read/1-write algorithmic memory read checker.
package algo_chk_pkg;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_MISSING_VLD  = 3'd1,
    ERR_SPURIOUS_VLD = 3'd2,
    ERR_DATA         = 3'd3,
    ERR_FLAGS        = 3'd4
  } err_code_e;

  // Per-cycle event count width; large enough for up to 8 read ports.
  localparam int unsigned CNTW = 4;

  // Adds inc to cur and clamps the result at the all-ones value of a bits-wide counter.
  function automatic logic [31:0] sat_add(input logic [31:0] cur,
                                          input logic [31:0] inc,
                                          input int unsigned bits);
    logic [32:0] sum;
    logic [32:0] max;
    max = (33'd1 << bits) - 33'd1;
    sum = {1'b0, cur} + {1'b0, inc};
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/algo_chk_dly_pipe.sv
// Per-port DELAY-stage shift register carrying a predicted read response to its compare cycle.
module algo_chk_dly_pipe #(
  parameter int unsigned BITADDR = 13,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DELAY   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_issue,
  input  logic [BITADDR-1:0] in_adr,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               out_issue,
  output logic [BITADDR-1:0] out_adr,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid
);

  localparam int unsigned EW = BITADDR + WIDTH + 2;

  logic [EW-1:0] stage_q [DELAY];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DELAY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= {in_issue, in_adr, in_data, in_valid};
      for (int unsigned i = 1; i < DELAY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign {out_issue, out_adr, out_data, out_valid} = stage_q[DELAY-1];

endmodule

// File: rtl/algo_nr1w_rd_checker.sv
// Run-time read checker for N-read/1-write memories: shadows writes, predicts reads at a
// fixed latency and reports mismatches through saturating counters and a sticky first error.
module algo_nr1w_rd_checker
  import algo_chk_pkg::*;
#(
  parameter int unsigned NUMRDPT = 2,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUMADDR = 8192,
  parameter int unsigned BITADDR = 13,
  parameter int unsigned DELAY   = 2,
  parameter int unsigned RDWRBYP = 0,
  parameter int unsigned BITECNT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ready,
  input  logic                       write,
  input  logic [BITADDR-1:0]         wr_adr,
  input  logic [WIDTH-1:0]           din,
  input  logic [NUMRDPT-1:0]         read,
  input  logic [NUMRDPT*BITADDR-1:0] rd_adr,
  input  logic [NUMRDPT-1:0]         rd_vld,
  input  logic [NUMRDPT*WIDTH-1:0]   rd_dout,
  input  logic [NUMRDPT-1:0]         rd_serr,
  input  logic [NUMRDPT-1:0]         rd_derr,
  output logic                       err_vld,
  output logic [2:0]                 err_code,
  output logic [BITECNT-1:0]         err_cnt,
  output logic [BITECNT-1:0]         chk_cnt,
  output logic [BITECNT-1:0]         derr_cnt,
  output logic                       first_vld,
  output logic [2:0]                 first_port,
  output logic [BITADDR-1:0]         first_adr
);

  logic [WIDTH-1:0]   mem_q [NUMADDR];
  logic [NUMADDR-1:0] mvld_q;

  logic [NUMRDPT-1:0] pipe_issue;
  logic [NUMRDPT-1:0] pipe_valid;
  logic [BITADDR-1:0] pipe_adr  [NUMRDPT];
  logic [WIDTH-1:0]   pipe_data [NUMRDPT];

  // Shadow store; data is deliberately left uninitialised, only valid bits reset.
  always_ff @(posedge clk) begin
    if (rst && write && ready) mem_q[wr_adr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) mvld_q <= '0;
    else if (write && ready) mvld_q[wr_adr] <= 1'b1;
  end

  // Capture the predicted response at issue time, honouring the same-cycle bypass mode.
  for (genvar g = 0; g < int'(NUMRDPT); g++) begin : g_port
    logic [BITADDR-1:0] radr;
    logic               issue;
    logic               hit;

    assign radr  = rd_adr[g*BITADDR +: BITADDR];
    assign issue = read[g] & ready;
    assign hit   = write && (wr_adr == radr) && (RDWRBYP != 0);

    algo_chk_dly_pipe #(
      .BITADDR (BITADDR),
      .WIDTH   (WIDTH),
      .DELAY   (DELAY)
    ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_issue  (issue),
      .in_adr    (issue ? radr : '0),
      .in_data   (issue ? (hit ? din : mem_q[radr]) : '0),
      .in_valid  (issue & (hit | mvld_q[radr])),
      .out_issue (pipe_issue[g]),
      .out_adr   (pipe_adr[g]),
      .out_data  (pipe_data[g]),
      .out_valid (pipe_valid[g])
    );
  end

  err_code_e          code_c [NUMRDPT];
  logic [CNTW-1:0]    nfail_c;
  logic [CNTW-1:0]    nchk_c;
  logic [CNTW-1:0]    nderr_c;
  err_code_e          lo_code_c;
  logic [2:0]         lo_port_c;
  logic [BITADDR-1:0] lo_adr_c;

  // Per-port verdict for the entries leaving the pipe this cycle.
  always_comb begin
    nfail_c = '0;
    nchk_c  = '0;
    nderr_c = '0;
    for (int p = 0; p < int'(NUMRDPT); p++) begin
      code_c[p] = ERR_NONE;
      if (pipe_issue[p] && !rd_vld[p]) begin
        code_c[p] = ERR_MISSING_VLD;
      end else if (!pipe_issue[p] && rd_vld[p] && ready) begin
        code_c[p] = ERR_SPURIOUS_VLD;
      end else if (pipe_issue[p] && rd_vld[p]) begin
        if (rd_derr[p]) nderr_c = nderr_c + CNTW'(1);
        if (rd_serr[p] && rd_derr[p]) begin
          code_c[p] = ERR_FLAGS;
        end else if (!rd_derr[p] && pipe_valid[p]) begin
          nchk_c = nchk_c + CNTW'(1);
          if (rd_dout[p*WIDTH +: WIDTH] != pipe_data[p]) code_c[p] = ERR_DATA;
        end
      end
      if (code_c[p] != ERR_NONE) nfail_c = nfail_c + CNTW'(1);
    end
  end

  // Scanning downwards leaves the lowest-numbered failing port.
  always_comb begin
    lo_code_c = ERR_NONE;
    lo_port_c = '0;
    lo_adr_c  = '0;
    for (int p = int'(NUMRDPT) - 1; p >= 0; p--) begin
      if (code_c[p] != ERR_NONE) begin
        lo_code_c = code_c[p];
        lo_port_c = 3'(p);
        lo_adr_c  = pipe_adr[p];
      end
    end
  end

  logic               err_vld_q,   err_vld_d;
  err_code_e          err_code_q,  err_code_d;
  logic [BITECNT-1:0] err_cnt_q,   err_cnt_d;
  logic [BITECNT-1:0] chk_cnt_q,   chk_cnt_d;
  logic [BITECNT-1:0] derr_cnt_q,  derr_cnt_d;
  logic               first_vld_q, first_vld_d;
  logic [2:0]         first_port_q, first_port_d;
  logic [BITADDR-1:0] first_adr_q, first_adr_d;

  always_comb begin
    err_vld_d    = (nfail_c != '0);
    err_code_d   = lo_code_c;
    err_cnt_d    = BITECNT'(sat_add(32'(err_cnt_q),  32'(nfail_c), BITECNT));
    chk_cnt_d    = BITECNT'(sat_add(32'(chk_cnt_q),  32'(nchk_c),  BITECNT));
    derr_cnt_d   = BITECNT'(sat_add(32'(derr_cnt_q), 32'(nderr_c), BITECNT));
    first_vld_d  = first_vld_q;
    first_port_d = first_port_q;
    first_adr_d  = first_adr_q;
    if (!first_vld_q && err_vld_d) begin
      first_vld_d  = 1'b1;
      first_port_d = lo_port_c;
      first_adr_d  = lo_adr_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_vld_q    <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_cnt_q    <= '0;
      chk_cnt_q    <= '0;
      derr_cnt_q   <= '0;
      first_vld_q  <= 1'b0;
      first_port_q <= '0;
      first_adr_q  <= '0;
    end else begin
      err_vld_q    <= err_vld_d;
      err_code_q   <= err_code_d;
      err_cnt_q    <= err_cnt_d;
      chk_cnt_q    <= chk_cnt_d;
      derr_cnt_q   <= derr_cnt_d;
      first_vld_q  <= first_vld_d;
      first_port_q <= first_port_d;
      first_adr_q  <= first_adr_d;
    end
  end

  assign err_vld    = err_vld_q;
  assign err_code   = err_code_q;
  assign err_cnt    = err_cnt_q;
  assign chk_cnt    = chk_cnt_q;
  assign derr_cnt   = derr_cnt_q;
  assign first_vld  = first_vld_q;
  assign first_port = first_port_q;
  assign first_adr  = first_adr_q;

endmodule

// File: doc/algo_nr1w_rd_checker.md
# algo_nr1w_rd_checker

Parametrised run-time read checker for N-read/1-write algorithmic memories. It keeps a shadow copy of the memory and predicts every read response at a fixed latency. It compares the DUT's `rd_vld`/`rd_dout`/`rd_serr`/`rd_derr` against that prediction and reports mismatches through counters and a sticky first-error record. It sits beside the memory top as a bound/instantiated monitor and generalises the single-port 1r1w wrapper to NUMRDPT read ports, configurable latency and same-cycle read/write bypass mode.

## Interface
- NUMRDPT, 2: number of read ports (1..8)
- WIDTH, 32: data width
- NUMADDR, 8192: memory depth
- BITADDR, 13: address width, ceil(log2(NUMADDR))
- DELAY, 2: read latency in cycles, read to rd_vld (1..16)
- RDWRBYP, 0: same-cycle same-address read returns 0 = old data, 1 = new data
- BITECNT, 16: error/check counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-low
- ready  in  1  DUT ready; checking is disabled while 0
- write  in  1  write strobe
- wr_adr  in  BITADDR  write address
- din  in  WIDTH  write data
- read  in  NUMRDPT  per-port read strobe
- rd_adr  in  NUMRDPT*BITADDR  per-port read address (port p at [p*BITADDR +: BITADDR])
- rd_vld  in  NUMRDPT  DUT read valid
- rd_dout  in  NUMRDPT*WIDTH  DUT read data
- rd_serr  in  NUMRDPT  DUT single-bit-corrected flag
- rd_derr  in  NUMRDPT  DUT uncorrectable flag
- err_vld  out  1  pulse: at least one mismatch this cycle
- err_code  out  3  code of lowest-numbered failing port this cycle
- err_cnt  out  BITECNT  saturating total mismatch count
- chk_cnt  out  BITECNT  saturating count of data comparisons performed
- derr_cnt  out  BITECNT  saturating count of rd_derr reports
- first_vld  out  1  sticky: first error captured
- first_port  out  3  port of first error
- first_adr  out  BITADDR  address of first error

## Operation
- Shadow store: NUMADDR x WIDTH data plus NUMADDR valid bits. Valid bits clear on reset. A write with `ready=1` sets data and valid.
- Read prediction: for each port with `read[p] & ready`, capture {issue=1, adr, exp_data, exp_valid} into a DELAY-stage pipe.
  - On a same-address write in the same cycle: RDWRBYP=0 captures pre-write shadow data and valid; RDWRBYP=1 captures din with exp_valid=1.
- Compare, in the cycle a pipe entry exits (stage DELAY) for port p:
  - issue=1, rd_vld=0: error ERR_MISSING_VLD.
  - issue=0, rd_vld=1: error ERR_SPURIOUS_VLD.
  - issue=1, rd_vld=1, rd_derr=1: derr_cnt++. No data compare. Not an error.
  - issue=1, rd_vld=1, exp_valid=1, no derr: chk_cnt++. If rd_dout != exp_data, error ERR_DATA. rd_serr does not excuse a mismatch.
  - exp_valid=0 (never written): no data compare and no chk_cnt increment; vld rules still apply.
  - rd_serr & rd_derr both 1: error ERR_FLAGS, takes priority over ERR_DATA.
- err_cnt adds the number of failing ports that cycle (0..NUMRDPT) and saturates at all-ones. The other counters also saturate.
- First error: when first_vld=0 and any port fails, record the lowest failing port and its address and set first_vld. It holds until reset.
- `ready=0`: no captures and no shadow updates. Entries already in the pipe still drain and are compared.

## Timing
- Reset (rst=0 at a clk edge): pipes, valid bits, counters, err_vld, err_code, first_* all clear to 0 on that edge. Shadow data is not cleared.
- Reset mid-flight discards in-flight reads. A rd_vld arriving after reset with no issue is flagged spurious only if ready=1.
- A read at cycle t is compared at cycle t+DELAY. err_vld, err_code and the counters update at t+DELAY+1 (registered).
- Back-to-back reads on every port every cycle are supported with no stall.
- A write at t is visible to reads issued at t+1 (and at t when RDWRBYP=1).

## Structure
- Package `algo_chk_pkg`: err_code enum (ERR_NONE=0, ERR_MISSING_VLD=1, ERR_SPURIOUS_VLD=2, ERR_DATA=3, ERR_FLAGS=4) and a saturating-increment function.
- Sub-module `algo_chk_dly_pipe`: one-port DELAY-stage shift register of {issue, adr, exp_data, exp_valid} with synchronous clear. Instantiate it NUMRDPT times.

## Test plan
- Write adr 5 = 0xA5A5_0001, then read adr 5 on port 1. DUT returns the same data at t+2 -> chk_cnt=1, err_cnt=0, err_vld never asserted.
- Same read, DUT returns 0xA5A5_0000 -> err_vld pulse at t+3, err_code=3, first_port=1, first_adr=5, err_cnt=1.
- RDWRBYP=0: adr 9 holds 0x11; in the same cycle write 0x22 to adr 9 and read adr 9. DUT returns 0x11 -> pass; returning 0x22 -> ERR_DATA.
- Read on ports 0 and 1 with rd_vld withheld, and rd_vld[2] raised with no read -> err_cnt += 3, err_code=1, first_port=0.
- rd_derr=1 with garbage data -> derr_cnt=1 and no error. rd_serr=rd_derr=1 -> ERR_FLAGS.
- Force 2^BITECNT+3 data errors -> err_cnt stays at all-ones. Then assert rst=0 for one cycle mid-stream -> all outputs 0 and in-flight reads dropped.
